hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
- Parametrised successor to the single-cycle hazard unit. Detects load-use hazards, control (branch-taken) hazards and data-memory wait states.
- Drives PC / IF-ID / ID-EX enables and flushes for a 5-stage pipeline.
- Multi-cycle load-use stalls use a counter-driven FSM. Memory back-pressure freezes the front end, and a saturating counter records stall cycles.
- Sits between the decode/execute pipeline registers and the fetch unit. ALU-to-ALU dependencies are left to the forwarding unit.

Parameters:
- REG_AW, 2, register address width (register count = 2**REG_AW).
- LOAD_STALL, 1, bubble cycles per load-use hazard (legal range 1..15).
- PERF_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- if_id_ra  in  REG_AW  source A of the instruction in decode
- if_id_rb  in  REG_AW  source B of the instruction in decode
- if_id_ra_used  in  1  decode instruction reads ra
- if_id_rb_used  in  1  decode instruction reads rb
- id_ex_rd  in  REG_AW  destination of the instruction in execute
- id_ex_mem_read  in  1  execute instruction is a load (LDD, POP, ...)
- bt  in  1  branch taken, resolved in EX
- mem_busy  in  1  data memory not ready; pipeline must freeze
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID register enable
- id_ex_en  out  1  ID/EX register enable
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_flush  out  1  insert bubble into ID/EX
- stall_active  out  1  high in any load-use stall cycle
- stall_cycles  out  PERF_W  saturating count of stall + freeze cycles

Behaviour:
- Reset (rst=1 at a clk edge): state←RUN, cnt←0, stall_cycles←0.
- While rst=1, outputs are forced to: pc_en=0, if_id_en=0, id_ex_en=1, if_id_flush=1, id_ex_flush=1, stall_active=0. This drains the pipeline.
- Reset mid-stall aborts the stall and returns to RUN.
- hazard = id_ex_mem_read & ((if_id_ra_used & ra==rd) | (if_id_rb_used & rb==rd)). It is combinational with zero latency.
- Output priority, highest first:
  - freeze: mem_busy=1
  - branch: bt=1
  - stall: hazard in RUN, or state LU_STALL
  - run
- freeze outputs:
  - pc_en=0, if_id_en=0, id_ex_en=0, both flushes=0.
  - FSM state and cnt hold. bt is ignored because EX is frozen and bt is re-presented later.
- branch outputs:
  - pc_en=1, if_id_en=1, id_ex_en=1, if_id_flush=1, id_ex_flush=1.
  - Any pending stall is cancelled: state←RUN, cnt←0.
- stall outputs: pc_en=0, if_id_en=0, id_ex_en=1, if_id_flush=0, id_ex_flush=1, stall_active=1.
- run outputs: all enables=1, all flushes=0.
- FSM has two states, RUN and LU_STALL:
  - RUN & hazard & !mem_busy & !bt: if LOAD_STALL==1, stay in RUN (one-cycle stall). Otherwise go to LU_STALL with cnt←LOAD_STALL-1.
  - LU_STALL & !mem_busy & !bt: cnt←cnt-1. When cnt==1, go to RUN.
  - Hazard is not re-evaluated inside LU_STALL. On return to RUN it is re-evaluated normally; EX then holds a bubble, so it is normally clear.
- cnt width: $clog2(LOAD_STALL+1). cnt never wraps below 0.
- stall_cycles increments on every non-reset cycle with stall or freeze active. It saturates at all-ones with no wrap.
- Total stall for one load-use hazard with no freeze is exactly LOAD_STALL cycles.

Decomposition:
- Shared package hu_pkg:
  - state enum {RUN, LU_STALL}
  - constant pipeline-control bundle values: CTRL_RUN, CTRL_STALL, CTRL_FREEZE, CTRL_FLUSH, CTRL_RESET
- Sub-module sat_counter (parametrised width, inc, clr) for stall_cycles. It is reused by other perf counters.

Test Plan:
1. Defaults; ra=0, rb=1, rd=2, mem_read=0, bt=0 → pc_en=1, if_id_en=1, flushes=0, stall_cycles unchanged.
2. ra=1, rd=1, ra_used=1, mem_read=1, LOAD_STALL=1 → one cycle of pc_en=0, if_id_en=0, id_ex_flush=1. Repeat with rb=1, ra=3: same response. Repeat with rb_used=0: no stall.
3. LOAD_STALL=3, hazard on RA for one cycle → stall_active=1 for exactly 3 consecutive cycles, then RUN. stall_cycles=3.
4. LOAD_STALL=3, mem_busy=1 for 2 cycles during the 2nd stall cycle → 2 freeze cycles (all enables 0), then the stall resumes. Total 5 non-run cycles; stall_cycles=5.
5. Hazard and bt=1 in the same cycle → branch wins: pc_en=1, if_id_flush=1, id_ex_flush=1, state RUN. bt=1 with mem_busy=1 → freeze, no flush.
6. rst=1 asserted in LU_STALL → outputs take reset values the same cycle; after release, state RUN and stall_cycles=0. PERF_W=2 with 5 stall cycles → stall_cycles saturates at 3.

Source files
------------

// File: rtl/hu_pkg.sv
// Shared types and pipeline-control bundle constants for the hazard control unit.
// Field order of ctrl_t fixes the bit layout of every CTRL_* constant below.
package hu_pkg;

    typedef enum logic {
        RUN,
        LU_STALL
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic stall_active;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN    = ctrl_t'(6'b111_000);
    localparam ctrl_t CTRL_STALL  = ctrl_t'(6'b001_011);
    localparam ctrl_t CTRL_FREEZE = ctrl_t'(6'b000_000);
    localparam ctrl_t CTRL_FLUSH  = ctrl_t'(6'b111_110);
    localparam ctrl_t CTRL_RESET  = ctrl_t'(6'b001_110);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use / branch / memory-wait hazard control for a 5-stage pipeline.
// Priority: freeze (mem_busy) > branch flush > load-use stall > run.
module hazard_ctrl_unit
    import hu_pkg::*;
#(
    parameter int unsigned REG_AW     = 2,
    parameter int unsigned LOAD_STALL = 1,
    parameter int unsigned PERF_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] if_id_ra,
    input  logic [REG_AW-1:0] if_id_rb,
    input  logic              if_id_ra_used,
    input  logic              if_id_rb_used,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic              id_ex_mem_read,
    input  logic              bt,
    input  logic              mem_busy,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              stall_active,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int unsigned CNT_W = $clog2(LOAD_STALL + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard;
    logic             perf_inc;
    ctrl_t            ctrl;

    assign hazard = id_ex_mem_read &
                    ((if_id_ra_used & (if_id_ra == id_ex_rd)) |
                     (if_id_rb_used & (if_id_rb == id_ex_rd)));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ctrl     = CTRL_RUN;
        perf_inc = 1'b0;
        if (rst) begin
            ctrl = CTRL_RESET;
        end else if (mem_busy) begin
            // EX is frozen, so bt will be presented again once memory is ready.
            ctrl     = CTRL_FREEZE;
            perf_inc = 1'b1;
        end else if (bt) begin
            ctrl    = CTRL_FLUSH;
            state_d = RUN;
            cnt_d   = '0;
        end else if ((state_q == LU_STALL) || hazard) begin
            ctrl     = CTRL_STALL;
            perf_inc = 1'b1;
            if (state_q == RUN) begin
                if (LOAD_STALL > 1) begin
                    state_d = LU_STALL;
                    cnt_d   = CNT_W'(LOAD_STALL - 1);
                end
            end else begin
                cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    sat_counter #(
        .WIDTH(PERF_W)
    ) u_stall_ctr (
        .clk  (clk),
        .rst  (rst),
        .inc  (perf_inc),
        .clr  (1'b0),
        .count(stall_cycles)
    );

    assign pc_en        = ctrl.pc_en;
    assign if_id_en     = ctrl.if_id_en;
    assign id_ex_en     = ctrl.id_ex_en;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign stall_active = ctrl.stall_active;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit; three instances share stimulus:
// LOAD_STALL=1, LOAD_STALL=3, and LOAD_STALL=3 with a 2-bit perf counter.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] ra, rb, rd;
    logic       ra_used, rb_used, mem_read, bt, mem_busy;

    logic        pc1, ifen1, exen1, iff1, exf1, sa1;
    logic [15:0] sc1;
    logic        pc3, ifen3, exen3, iff3, exf3, sa3;
    logic [15:0] sc3;
    logic        pcs, ifens, exens, iffs, exfs, sas;
    logic [1:0]  scs;

    int checks   = 0;
    int failures = 0;

    // {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush}
    localparam logic [4:0] B_RUN    = 5'b11100;
    localparam logic [4:0] B_STALL  = 5'b00101;
    localparam logic [4:0] B_FREEZE = 5'b00000;
    localparam logic [4:0] B_FLUSH  = 5'b11111;
    localparam logic [4:0] B_RESET  = 5'b00111;

    wire [4:0] b1 = {pc1, ifen1, exen1, iff1, exf1};
    wire [4:0] b3 = {pc3, ifen3, exen3, iff3, exf3};
    wire [4:0] bs = {pcs, ifens, exens, iffs, exfs};

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_AW(2), .LOAD_STALL(1), .PERF_W(16)) u_ls1 (
        .clk(clk), .rst(rst), .if_id_ra(ra), .if_id_rb(rb), .if_id_ra_used(ra_used),
        .if_id_rb_used(rb_used), .id_ex_rd(rd), .id_ex_mem_read(mem_read), .bt(bt),
        .mem_busy(mem_busy), .pc_en(pc1), .if_id_en(ifen1), .id_ex_en(exen1),
        .if_id_flush(iff1), .id_ex_flush(exf1), .stall_active(sa1), .stall_cycles(sc1)
    );

    hazard_ctrl_unit #(.REG_AW(2), .LOAD_STALL(3), .PERF_W(16)) u_ls3 (
        .clk(clk), .rst(rst), .if_id_ra(ra), .if_id_rb(rb), .if_id_ra_used(ra_used),
        .if_id_rb_used(rb_used), .id_ex_rd(rd), .id_ex_mem_read(mem_read), .bt(bt),
        .mem_busy(mem_busy), .pc_en(pc3), .if_id_en(ifen3), .id_ex_en(exen3),
        .if_id_flush(iff3), .id_ex_flush(exf3), .stall_active(sa3), .stall_cycles(sc3)
    );

    hazard_ctrl_unit #(.REG_AW(2), .LOAD_STALL(3), .PERF_W(2)) u_sat (
        .clk(clk), .rst(rst), .if_id_ra(ra), .if_id_rb(rb), .if_id_ra_used(ra_used),
        .if_id_rb_used(rb_used), .id_ex_rd(rd), .id_ex_mem_read(mem_read), .bt(bt),
        .mem_busy(mem_busy), .pc_en(pcs), .if_id_en(ifens), .id_ex_en(exens),
        .if_id_flush(iffs), .id_ex_flush(exfs), .stall_active(sas), .stall_cycles(scs)
    );

    // Inputs change 1ns after posedge; checks happen 4ns after posedge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ra = 2'd0; rb = 2'd1; rd = 2'd2;
        ra_used = 1'b1; rb_used = 1'b1; mem_read = 1'b0; bt = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic hazard_ra();
        ra = 2'd1; rb = 2'd0; rd = 2'd1; ra_used = 1'b1; rb_used = 1'b0; mem_read = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        #3;
        checks++;
        if (b3 !== B_RESET || sa3 !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b sa=%b, want %b sa=0", b3, sa3, B_RESET);
        end
        rst = 1'b0;
        next_cycle();
        #3;
        checks++;
        if (sc3 !== 16'd0) begin
            failures++;
            $display("FAIL reset_counter: got %0d, want 0", sc3);
        end
    endtask

    task automatic test_run();
        do_reset();
        idle_inputs();
        #3;
        checks++;
        if (b3 !== B_RUN || sa3 !== 1'b0) begin
            failures++;
            $display("FAIL run_outputs: got %b sa=%b, want %b sa=0", b3, sa3, B_RUN);
        end
        next_cycle();
        #3;
        checks++;
        if (sc3 !== 16'd0) begin
            failures++;
            $display("FAIL run_counter: got %0d, want 0", sc3);
        end
    endtask

    task automatic test_single_stall();
        do_reset();
        hazard_ra();
        #3;
        checks++;
        if (b1 !== B_STALL || sa1 !== 1'b1) begin
            failures++;
            $display("FAIL ls1_ra_stall: got %b sa=%b, want %b sa=1", b1, sa1, B_STALL);
        end
        next_cycle();
        idle_inputs();
        #3;
        checks++;
        if (b1 !== B_RUN || sc1 !== 16'd1) begin
            failures++;
            $display("FAIL ls1_after: got %b cnt=%0d, want %b cnt=1", b1, sc1, B_RUN);
        end
        next_cycle();
        ra = 2'd3; rb = 2'd1; rd = 2'd1; ra_used = 1'b1; rb_used = 1'b1; mem_read = 1'b1;
        #3;
        checks++;
        if (b1 !== B_STALL || sa1 !== 1'b1) begin
            failures++;
            $display("FAIL ls1_rb_stall: got %b sa=%b, want %b sa=1", b1, sa1, B_STALL);
        end
        next_cycle();
        rb_used = 1'b0;
        #3;
        checks++;
        if (b1 !== B_RUN || sa1 !== 1'b0) begin
            failures++;
            $display("FAIL ls1_rb_unused: got %b sa=%b, want %b sa=0", b1, sa1, B_RUN);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_multi_stall();
        do_reset();
        hazard_ra();
        for (int i = 0; i < 4; i++) begin
            #3;
            checks++;
            if (sa3 !== (i < 3) || b3 !== ((i < 3) ? B_STALL : B_RUN)) begin
                failures++;
                $display("FAIL ls3_cycle%0d: got %b sa=%b, want sa=%0d", i, b3, sa3, i < 3);
            end
            next_cycle();
            idle_inputs();
        end
        #3;
        checks++;
        if (sc3 !== 16'd3) begin
            failures++;
            $display("FAIL ls3_counter: got %0d, want 3", sc3);
        end
    endtask

    task automatic test_freeze();
        logic [4:0] exp_b [6];
        logic       busy  [6];
        exp_b = '{B_STALL, B_FREEZE, B_FREEZE, B_STALL, B_STALL, B_RUN};
        busy  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        hazard_ra();
        for (int i = 0; i < 6; i++) begin
            mem_busy = busy[i];
            #3;
            checks++;
            if (b3 !== exp_b[i]) begin
                failures++;
                $display("FAIL freeze_cycle%0d: got %b, want %b", i, b3, exp_b[i]);
            end
            next_cycle();
            idle_inputs();
        end
        #3;
        checks++;
        if (sc3 !== 16'd5) begin
            failures++;
            $display("FAIL freeze_counter: got %0d, want 5", sc3);
        end
    endtask

    task automatic test_branch();
        do_reset();
        hazard_ra();
        bt = 1'b1;
        #3;
        checks++;
        if (b3 !== B_FLUSH || sa3 !== 1'b0) begin
            failures++;
            $display("FAIL branch_wins: got %b sa=%b, want %b sa=0", b3, sa3, B_FLUSH);
        end
        next_cycle();
        idle_inputs();
        #3;
        checks++;
        if (b3 !== B_RUN) begin
            failures++;
            $display("FAIL branch_then_run: got %b, want %b", b3, B_RUN);
        end
        next_cycle();
        hazard_ra();
        next_cycle();
        idle_inputs();
        bt = 1'b1;
        #3;
        checks++;
        if (b3 !== B_FLUSH) begin
            failures++;
            $display("FAIL branch_in_stall: got %b, want %b", b3, B_FLUSH);
        end
        next_cycle();
        idle_inputs();
        #3;
        checks++;
        if (b3 !== B_RUN || sa3 !== 1'b0) begin
            failures++;
            $display("FAIL branch_cancel: got %b sa=%b, want %b sa=0", b3, sa3, B_RUN);
        end
        next_cycle();
        bt = 1'b1;
        mem_busy = 1'b1;
        #3;
        checks++;
        if (b3 !== B_FREEZE) begin
            failures++;
            $display("FAIL branch_frozen: got %b, want %b", b3, B_FREEZE);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        hazard_ra();
        next_cycle();
        idle_inputs();
        rst = 1'b1;
        #3;
        checks++;
        if (b3 !== B_RESET || sa3 !== 1'b0) begin
            failures++;
            $display("FAIL rst_in_stall: got %b sa=%b, want %b sa=0", b3, sa3, B_RESET);
        end
        next_cycle();
        rst = 1'b0;
        #3;
        checks++;
        if (b3 !== B_RUN || sc3 !== 16'd0) begin
            failures++;
            $display("FAIL rst_release: got %b cnt=%0d, want %b cnt=0", b3, sc3, B_RUN);
        end
        next_cycle();
    endtask

    task automatic test_saturation();
        do_reset();
        hazard_ra();
        for (int i = 0; i < 5; i++) begin
            #3;
            checks++;
            if (bs !== B_STALL) begin
                failures++;
                $display("FAIL sat_stall%0d: got %b, want %b", i, bs, B_STALL);
            end
            if (i == 2) begin
                checks++;
                if (scs !== 2'd2) begin
                    failures++;
                    $display("FAIL sat_mid: got %0d, want 2", scs);
                end
            end
            next_cycle();
        end
        idle_inputs();
        #3;
        checks++;
        if (scs !== 2'd3) begin
            failures++;
            $display("FAIL sat_final: got %0d, want 3", scs);
        end
        next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_run();
        test_single_stall();
        test_multi_stall();
        test_freeze();
        test_branch();
        test_reset_mid_stall();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
